aoi_bist_ctrl: RTL and testbench



---
 rtl/aoi_bist_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_aoi_bist_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aoi_bist_ctrl.sv
// aoi_bist_ctrl: built-in self-test sequencer for a 4-input AND-OR-INVERT cell,
// y = ~((a&b)|(c&d)).
//
// On start it sweeps {a,b,c,d} = 0..15. Each vector is held for SETTLE_CYC
// cycles and then checked for one cycle, so one vector takes SETTLE_CYC+1
// clocks. The sampled aoi_y is compared against an internal golden model.
// The block reports pass/fail, the number of mismatching vectors and the
// first failing vector.
//
// Optional build macro AOI_BIST_MISR_EN: adds an 8-bit MISR output 'sig'.
// 'sig' compresses every sampled aoi_y, so a single readout can be compared
// with a known-good signature.
module aoi_bist_ctrl #(
  parameter int SETTLE_CYC = 2,   // 1..15 cycles between driving and sampling
  parameter int WAIT_W     = 4    // must hold SETTLE_CYC-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       aoi_y,
  output logic [3:0] aoi_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail,
  output logic       fail_vld
`ifdef AOI_BIST_MISR_EN
  ,
  output logic [7:0] sig
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        vec_q, vec_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [3:0]        aoi_in_q, aoi_in_d;
  logic [4:0]        err_q, err_d;
  logic [3:0]        ff_q, ff_d;
  logic              fv_q, fv_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
`ifdef AOI_BIST_MISR_EN
  logic [7:0]        sig_q, sig_d;
`endif

  // Golden response for the vector under test, and the mismatch flag
  logic exp_y;
  logic mis;
  assign exp_y = ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
  assign mis   = (aoi_y != exp_y);

  // State and result registers; reset returns to IDLE from any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      wcnt_q   <= '0;
      aoi_in_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef AOI_BIST_MISR_EN
      sig_q    <= 8'hFF;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      wcnt_q   <= wcnt_d;
      aoi_in_q <= aoi_in_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
`ifdef AOI_BIST_MISR_EN
      sig_q    <= sig_d;
`endif
    end
  end

  // Next-state logic: launch a sweep, settle each vector, check, advance
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    wcnt_d   = wcnt_q;
    aoi_in_d = aoi_in_q;
    err_d    = err_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    done_d   = done_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
`ifdef AOI_BIST_MISR_EN
    sig_d    = sig_q;
`endif

    unique case (state_q)
      // start is only honoured here, so a pulse during a sweep has no effect.
      // Starting from DONE clears the previous results.
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d    = '0;
          aoi_in_d = '0;
          wcnt_d   = '0;
          err_d    = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_WAIT;
`ifdef AOI_BIST_MISR_EN
          sig_d    = 8'hFF;
`endif
        end
      end

      // aoi_in stays stable while the cell output settles; aoi_y is ignored
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = '0;
          state_d = S_CHECK;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
      end

      // The only cycle that looks at aoi_y for this vector
      S_CHECK: begin
        if (mis) begin
          // At most 16 mismatches, so 5 bits never wrap
          err_d = err_q + 5'd1;
          if (!fv_q) begin
            ff_d = vec_q;
            fv_d = 1'b1;
          end
        end
`ifdef AOI_BIST_MISR_EN
        sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ aoi_y};
`endif
        if (vec_q == 4'd15) begin
          // pass uses the count that includes this last vector
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 5'd0);
        end else begin
          vec_d    = vec_q + 4'd1;
          aoi_in_d = vec_q + 4'd1;
          state_d  = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign aoi_in     = aoi_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_vld   = fv_q;
`ifdef AOI_BIST_MISR_EN
  assign sig        = sig_q;
`endif

endmodule

// File: tb/tb_aoi_bist_ctrl.sv
// Directed bench for aoi_bist_ctrl. A behavioural AOI model drives aoi_y and
// can be switched to a correct cell, stuck-at-1, stuck-at-0, or a cell that
// is wrong only on vector 9.
module tb_aoi_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       aoi_y;
  logic [3:0] aoi_in;
  logic       busy, done, pass, fail_vld;
  logic [4:0] err_cnt;
  logic [3:0] first_fail;
`ifdef AOI_BIST_MISR_EN
  logic [7:0] sig;
`endif

  int n_chk = 0;
  int n_err = 0;
  int mode  = 0;   // 0 correct, 1 stuck-1, 2 stuck-0, 3 wrong on vector 9

  aoi_bist_ctrl #(.SETTLE_CYC(2), .WAIT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .aoi_y      (aoi_y),
    .aoi_in     (aoi_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail),
    .fail_vld   (fail_vld)
`ifdef AOI_BIST_MISR_EN
    ,
    .sig        (sig)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic gold(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  // MISR reference over the 16-vector response, optionally flipping one vector
  function automatic logic [7:0] misr(input int flip_v);
    logic [7:0] s;
    logic       y;
    s = 8'hFF;
    for (int v = 0; v < 16; v++) begin
      y = gold(4'(v)) ^ (v == flip_v);
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ y};
    end
    return s;
  endfunction

  always_comb begin
    aoi_y = gold(aoi_in);
    case (mode)
      1:       aoi_y = 1'b1;
      2:       aoi_y = 1'b0;
      3:       aoi_y = gold(aoi_in) ^ (aoi_in == 4'd9);
      default: aoi_y = gold(aoi_in);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Full sweep: pulse start, optionally pulse start again pulse_at cycles
  // later, track aoi_in stepping and the start-to-done latency.
  task automatic run_sweep(input int pulse_at, output int cyc);
    int bad;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err_cnt, 0);
    chk("start_fv_clr", fail_vld, 0);
    bad = 0;
    if (aoi_in !== 4'd0) bad++;
    cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
      if (!done && aoi_in !== 4'(cyc / 3)) bad++;
    end
    start = 1'b0;
    chk("aoi_steps_bad", bad, 0);
    chk("done_latency", cyc, 48);
    chk("done_aoi_in", aoi_in, 15);
    chk("done_busy", busy, 0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_aoi_in"}, aoi_in, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_pass"}, pass, 0);
    chk({pfx, "_err"}, err_cnt, 0);
    chk({pfx, "_ff"}, first_fail, 0);
    chk({pfx, "_fv"}, fail_vld, 0);
`ifdef AOI_BIST_MISR_EN
    chk({pfx, "_sig"}, sig, 8'hFF);
`endif
  endtask

  initial begin
    int cyc;
    int k;
    rst   = 1'b0;
    start = 1'b0;
    #1 rst = 1'b1;
    #2 chk_reset_vals("rst0");   // before any clock edge: asynchronous
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Correct cell
    mode = 0;
    run_sweep(-1, cyc);
    chk("good_pass", pass, 1);
    chk("good_err", err_cnt, 0);
    chk("good_fv", fail_vld, 0);
`ifdef AOI_BIST_MISR_EN
    chk("good_sig", sig, misr(-1));
`endif

    // Stuck-at-1: vectors 3,7,11,12,13,14,15 fail
    mode = 1;
    run_sweep(-1, cyc);
    chk("s1_err", err_cnt, 7);
    chk("s1_ff", first_fail, 3);
    chk("s1_fv", fail_vld, 1);
    chk("s1_pass", pass, 0);

    // Restart from DONE after a failing run; results clear and rerun passes
    mode = 0;
    run_sweep(-1, cyc);
    chk("rerun_pass", pass, 1);
    chk("rerun_err", err_cnt, 0);

    // Stuck-at-0: the nine vectors with golden 1 fail, first is 0
    mode = 2;
    run_sweep(-1, cyc);
    chk("s0_err", err_cnt, 9);
    chk("s0_ff", first_fail, 0);
    chk("s0_fv", fail_vld, 1);
    chk("s0_pass", pass, 0);

    // start pulsed mid-sweep is ignored
    mode = 0;
    run_sweep(10, cyc);
    chk("busy_start_pass", pass, 1);
    chk("busy_start_err", err_cnt, 0);

    // Reset mid-sweep at vector 6
    pulse_start();
    k = 0;
    while (aoi_in !== 4'd6 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_v6", aoi_in, 6);
    chk("v6_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_aoi_in", aoi_in, 0);
    chk("idle_done", done, 0);
    run_sweep(-1, cyc);
    chk("post_rst_pass", pass, 1);

    // Cell wrong on vector 9 only
    mode = 3;
    run_sweep(-1, cyc);
    chk("v9_err", err_cnt, 1);
    chk("v9_ff", first_fail, 9);
    chk("v9_fv", fail_vld, 1);
    chk("v9_pass", pass, 0);
`ifdef AOI_BIST_MISR_EN
    chk("v9_sig", sig, misr(9));
    chk("v9_sig_differs", (sig != misr(-1)), 1);
    // signature holds while idling in DONE
    repeat (5) @(posedge clk);
    #1 chk("v9_sig_hold", sig, misr(9));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
